execute_stage: RTL and testbench

- Y86-64 pipeline execute stage (E); consumes the outputs of the decode-to-execute pipeline register and feeds the execute-to-memory pipeline register.
- Combinational ALU, source/function selection, branch/cmov condition evaluation.
- Holds the architectural condition-code register (ZF/SF/OF), which updates only for OPq when no downstream exception is pending.

---
 rtl/execute_stage.sv | 174 +++++++++++++++++
 tb/tb_execute_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand/function selection, ALU with flag generation,
// condition-code register and branch/cmov condition evaluation.
module execute_stage #(
  parameter int unsigned DATA_W   = 64,
  parameter logic [2:0]  STAT_AOK = 3'd1,
  parameter logic [2:0]  STAT_HLT = 3'd2,
  parameter logic [2:0]  STAT_ADR = 3'd3,
  parameter logic [2:0]  STAT_INS = 3'd4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        E_stat_i,
  input  logic [3:0]        E_icode_i,
  input  logic [3:0]        E_ifun_i,
  input  logic [DATA_W-1:0] E_valC_i,
  input  logic [DATA_W-1:0] E_valA_i,
  input  logic [DATA_W-1:0] E_valB_i,
  input  logic [3:0]        E_dstE_i,
  input  logic [3:0]        E_dstM_i,
  input  logic [2:0]        m_stat_i,
  input  logic [2:0]        W_stat_i,
  output logic [2:0]        e_stat_o,
  output logic [3:0]        e_icode_o,
  output logic [DATA_W-1:0] e_valE_o,
  output logic [DATA_W-1:0] e_valA_o,
  output logic [3:0]        e_dstE_o,
  output logic [3:0]        e_dstM_o,
  output logic              e_cnd_o,
  output logic [2:0]        cc_o
);

  // The datapath is only defined for 64 bits and distinct status codes.
  if (DATA_W != 64 || STAT_HLT == STAT_AOK || STAT_ADR == STAT_AOK ||
      STAT_INS == STAT_AOK) begin : g_bad_params
    $error("execute_stage: unsupported parameter set");
  end

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    A_ADD = 4'h0,
    A_SUB = 4'h1,
    A_AND = 4'h2,
    A_XOR = 4'h3
  } alufun_e;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'h0,
    C_LE     = 4'h1,
    C_L      = 4'h2,
    C_E      = 4'h3,
    C_NE     = 4'h4,
    C_GE     = 4'h5,
    C_G      = 4'h6
  } cond_e;

  localparam int unsigned       MSB  = DATA_W - 1;
  localparam logic [DATA_W-1:0] NEG8 = ~DATA_W'(7);
  localparam logic [DATA_W-1:0] POS8 = DATA_W'(8);

  icode_e            icode;
  logic [3:0]        alufun;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_t;
  logic              zf;
  logic              sf;
  logic              of;
  logic              set_cc;
  logic [2:0]        cc_q;
  logic [2:0]        cc_d;
  logic              cnd;

  assign icode  = icode_e'(E_icode_i);
  assign alufun = (icode == I_OPQ) ? E_ifun_i : A_ADD;

  // ALU operand selection by instruction class
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (icode)
      I_RRMOVQ, I_OPQ:              alu_a = E_valA_i;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC_i;
      I_CALL, I_PUSHQ:              alu_a = NEG8;
      I_RET, I_POPQ:                alu_a = POS8;
      default:                      alu_a = '0;
    endcase
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ:
        alu_b = E_valB_i;
      default:
        alu_b = '0;
    endcase
  end

  // ALU result and overflow; unknown functions yield zero with no overflow
  always_comb begin
    alu_t = '0;
    of    = 1'b0;
    case (alufun)
      A_ADD: begin
        alu_t = alu_b + alu_a;
        of    = (alu_a[MSB] == alu_b[MSB]) && (alu_t[MSB] != alu_a[MSB]);
      end
      A_SUB: begin
        alu_t = alu_b - alu_a;
        of    = (alu_a[MSB] != alu_b[MSB]) && (alu_t[MSB] != alu_b[MSB]);
      end
      A_AND:   alu_t = alu_b & alu_a;
      A_XOR:   alu_t = alu_b ^ alu_a;
      default: alu_t = '0;
    endcase
  end

  assign zf = (alu_t == '0);
  assign sf = alu_t[MSB];

  // CC updates only for OPq while nothing downstream has faulted
  assign set_cc = (icode == I_OPQ) && (m_stat_i == STAT_AOK) && (W_stat_i == STAT_AOK);

  always_comb begin
    cc_d = cc_q;
    if (set_cc) begin
      cc_d = {zf, sf, of};
    end
  end

  // Condition-code register, ZF set out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cc_q <= 3'b100;
    end else begin
      cc_q <= cc_d;
    end
  end

  // Branch/cmov condition from the registered flags {ZF,SF,OF}
  always_comb begin
    cnd = 1'b0;
    case (E_ifun_i)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      C_L:      cnd = cc_q[1] ^ cc_q[0];
      C_E:      cnd = cc_q[2];
      C_NE:     cnd = ~cc_q[2];
      C_GE:     cnd = ~(cc_q[1] ^ cc_q[0]);
      C_G:      cnd = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
      default:  cnd = 1'b0;
    endcase
  end

  assign e_stat_o  = E_stat_i;
  assign e_icode_o = E_icode_i;
  assign e_valE_o  = alu_t;
  assign e_valA_o  = E_valA_i;
  assign e_dstE_o  = ((icode == I_RRMOVQ) && !cnd) ? 4'hF : E_dstE_i;
  assign e_dstM_o  = E_dstM_i;
  assign e_cnd_o   = cnd;
  assign cc_o      = cc_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_valC;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [3:0]  E_dstE;
  logic [3:0]  E_dstM;
  logic [2:0]  m_stat;
  logic [2:0]  W_stat;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic        e_cnd;
  logic [2:0]  cc;

  execute_stage #(.DATA_W(64)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .E_stat_i  (E_stat),
    .E_icode_i (E_icode),
    .E_ifun_i  (E_ifun),
    .E_valC_i  (E_valC),
    .E_valA_i  (E_valA),
    .E_valB_i  (E_valB),
    .E_dstE_i  (E_dstE),
    .E_dstM_i  (E_dstM),
    .m_stat_i  (m_stat),
    .W_stat_i  (W_stat),
    .e_stat_o  (e_stat),
    .e_icode_o (e_icode),
    .e_valE_o  (e_valE),
    .e_valA_o  (e_valA),
    .e_dstE_o  (e_dstE),
    .e_dstM_o  (e_dstM),
    .e_cnd_o   (e_cnd),
    .cc_o      (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        cnd;
    logic [2:0]  cc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [2:0]  mcc   = 3'b100;   // model of the architectural {ZF,SF,OF}

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Instruction-level meaning of the ALU: what valE each instruction produces.
  function automatic void ref_alu(input logic [3:0] ic, input logic [3:0] fn,
                                  input logic [63:0] c, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] t,
                                  output logic [2:0] flags);
    logic signed [64:0] w;
    logic               o;
    o = 1'b0;
    case (ic)
      4'h2:       t = a;
      4'h3:       t = c;
      4'h4, 4'h5: t = b + c;
      4'h8, 4'hA: t = b - 64'd8;
      4'h9, 4'hB: t = b + 64'd8;
      4'h6: begin
        case (fn)
          4'h0: begin
            t = b + a;
            w = $signed({b[63], b}) + $signed({a[63], a});
            o = (w != $signed({t[63], t}));
          end
          4'h1: begin
            t = b - a;
            w = $signed({b[63], b}) - $signed({a[63], a});
            o = (w != $signed({t[63], t}));
          end
          4'h2:    t = b & a;
          4'h3:    t = b ^ a;
          default: t = 64'd0;
        endcase
      end
      default: t = 64'd0;
    endcase
    flags = {t == 64'd0, t[63], o};
  endfunction

  function automatic logic ref_cond(input logic [3:0] fn, input logic [2:0] f);
    bit z, less;
    z    = f[2];
    less = (f[1] != f[0]);
    case (fn)
      4'h0:    return 1'b1;
      4'h1:    return less || z;
      4'h2:    return less;
      4'h3:    return z;
      4'h4:    return !z;
      4'h5:    return !less;
      4'h6:    return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] c,
                       input logic [63:0] a, input logic [63:0] b, input logic [3:0] de,
                       input logic [2:0] ms, input logic [2:0] ws, input bit do_rst);
    exp_t        e;
    logic [63:0] t;
    logic [2:0]  fl;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    E_stat  = 3'($urandom_range(0, 7));
    E_icode = ic;
    E_ifun  = fn;
    E_valC  = c;
    E_valA  = a;
    E_valB  = b;
    E_dstE  = de;
    E_dstM  = 4'($urandom);
    m_stat  = ms;
    W_stat  = ws;
    ref_alu(ic, fn, c, a, b, t, fl);
    e.stat  = E_stat;
    e.icode = ic;
    e.valE  = t;
    e.valA  = a;
    e.dstM  = E_dstM;
    if (do_rst) begin
      #2;
      rst = 1'b1;
      mcc = 3'b100;
    end
    e.cnd  = ref_cond(fn, mcc);
    e.dstE = (ic == 4'h2 && !e.cnd) ? 4'hF : de;
    e.cc   = mcc;
    sb.push_back(e);
    if (!do_rst && ic == 4'h6 && ms == 3'd1 && ws == 3'd1) mcc = fl;
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents one result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stat",  64'(e_stat),  64'(e.stat));
        chk("icode", 64'(e_icode), 64'(e.icode));
        chk("valE",  e_valE,       e.valE);
        chk("valA",  e_valA,       e.valA);
        chk("dstE",  64'(e_dstE),  64'(e.dstE));
        chk("dstM",  64'(e_dstM),  64'(e.dstM));
        chk("cnd",   64'(e_cnd),   64'(e.cnd));
        chk("cc",    64'(cc),      64'(e.cc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] pick_val();
    logic [63:0] specials [5];
    specials[0] = 64'd0;
    specials[1] = 64'd1;
    specials[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    specials[3] = 64'h8000_0000_0000_0000;
    specials[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [3:0] ic;
    rst = 1'b1;
    E_stat = 3'd1; E_icode = 4'h1; E_ifun = '0; E_valC = '0; E_valA = '0; E_valB = '0;
    E_dstE = 4'hF; E_dstM = 4'hF; m_stat = 3'd1; W_stat = 3'd1;
    repeat (2) @(posedge clk);

    // reset state and conditions on it
    issue(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 4'hF, 3'd1, 3'd1, 1'b0);
    issue(4'h7, 4'h4, 64'h0, 64'h0, 64'h0, 4'hF, 3'd1, 3'd1, 1'b0);
    // signed overflow on add, then equality via sub, then cmovl not taken
    issue(4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h2, 3'd1, 3'd1, 1'b0);
    issue(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 3'd1, 3'd1, 1'b0);
    issue(4'h6, 4'h1, 64'h0, 64'd5, 64'd5, 4'h2, 3'd1, 3'd1, 1'b0);
    issue(4'h2, 4'h2, 64'h0, 64'h1234, 64'h0, 4'h3, 3'd1, 3'd1, 1'b0);
    // stack and address arithmetic leave CC alone
    issue(4'hA, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4, 3'd1, 3'd1, 1'b0);
    issue(4'hB, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4, 3'd1, 3'd1, 1'b0);
    issue(4'h5, 4'h0, 64'h10, 64'h0, 64'h20, 4'hF, 3'd1, 3'd1, 1'b0);
    // produce a non-reset CC, then block writes with downstream faults
    issue(4'h6, 4'h1, 64'h0, 64'd1, 64'd0, 4'h2, 3'd1, 3'd1, 1'b0);
    issue(4'h6, 4'h3, 64'h0, 64'hFF, 64'hFF, 4'h2, 3'd3, 3'd1, 1'b0);
    issue(4'h6, 4'h3, 64'h0, 64'hFF, 64'hFF, 4'h2, 3'd1, 3'd2, 1'b0);
    issue(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF, 3'd1, 3'd1, 1'b0);
    // asynchronous reset while an OPq is in flight
    issue(4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h2, 3'd1, 3'd1, 1'b0);
    issue(4'h6, 4'h2, 64'h0, 64'h8000_0000_0000_0000, 64'hF000_0000_0000_0000, 4'h2, 3'd1, 3'd1, 1'b1);
    issue(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 4'hF, 3'd1, 3'd1, 1'b0);

    for (int unsigned i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    ic = 4'h6;
        2:       ic = 4'h2;
        3:       ic = 4'h7;
        default: ic = 4'($urandom);
      endcase
      issue(ic,
            ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6)),
            pick_val(), pick_val(), pick_val(), 4'($urandom),
            ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd1,
            ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd1,
            $urandom_range(0, 60) == 0);
    end

    repeat (3) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
